// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: synthetic OV7670-style DVP source emitting RGB565 test frames.
// Define DVP_TX_CONT_EN for back-to-back frames while start stays high at frame end.
module dvp_pattern_tx #(
   parameter int H_ACTIVE = 16,
   parameter int H_BLANK  = 4,
   parameter int V_ACTIVE = 8,
   parameter int VSYNC_W  = 3,
   parameter int V_BACK   = 2,
   parameter int V_FRONT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic [15:0] color,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  frame_cnt,
   output logic        pclk,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  d
);
   function automatic int imax(input int a, input int b);
      return a > b ? a : b;
   endfunction
   localparam int CW = $clog2(imax(imax(imax(2 * H_ACTIVE, H_BLANK), imax(VSYNC_W, V_BACK)), V_FRONT));
   localparam int LW = $clog2(V_ACTIVE);
   localparam logic [CW-1:0] VS_END = CW'(VSYNC_W - 1);
   localparam logic [CW-1:0] VB_END = CW'(V_BACK - 1);
   localparam logic [CW-1:0] LN_END = CW'(2 * H_ACTIVE - 1);
   localparam logic [CW-1:0] HB_END = CW'(H_BLANK - 1);
   localparam logic [CW-1:0] VF_END = CW'(V_FRONT - 1);
   localparam logic [LW-1:0] LAST_LINE = LW'(V_ACTIVE - 1);
   localparam logic [LW-1:0] HALF = LW'(V_ACTIVE / 2);
   typedef enum logic [2:0] {IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [LW-1:0] line, line_n;
   logic [1:0] mode_q, mode_n;
   logic [15:0] color_q, color_n, px;
   logic [7:0] fcnt_n, d_n;
   logic [5:0] x6;
   logic pclk_n, busy_n, done_n, vsync_n, href_n, restart;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         line       <= '0;
         mode_q     <= '0;
         color_q    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         pclk       <= 1'b0;
         vsync      <= 1'b0;
         href       <= 1'b0;
         d          <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         line       <= line_n;
         mode_q     <= mode_n;
         color_q    <= color_n;
         busy       <= busy_n;
         frame_done <= done_n;
         frame_cnt  <= fcnt_n;
         pclk       <= pclk_n;
         vsync      <= vsync_n;
         href       <= href_n;
         d          <= d_n;
      end
   end
   // Segment state advances only on the clk edge where pclk falls.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      line_n  = line;
      pclk_n  = busy & ~pclk;
      busy_n  = busy;
      done_n  = 1'b0;
      fcnt_n  = frame_cnt;
      mode_n  = mode_q;
      color_n = color_q;
      restart = 1'b0;
      if (!busy) restart = start;
      else if (pclk) begin
         cnt_n = cnt + CW'(1);
         case (state)
            VSYNC:  if (cnt == VS_END) begin state_n = VBACK; cnt_n = '0; end
            VBACK:  if (cnt == VB_END) begin state_n = LINE; cnt_n = '0; end
            LINE:   if (cnt == LN_END) begin state_n = HBLANK; cnt_n = '0; end
            HBLANK: if (cnt == HB_END) begin
                       state_n = (line == LAST_LINE) ? VFRONT : LINE;
                       line_n  = (line == LAST_LINE) ? line : line + LW'(1);
                       cnt_n   = '0;
                    end
            VFRONT: if (cnt == VF_END) begin
                       state_n = IDLE;
                       busy_n  = 1'b0;
                       done_n  = 1'b1;
                       fcnt_n  = frame_cnt + 8'd1;
`ifdef DVP_TX_CONT_EN
                       restart = start;
`else
                       restart = 1'b0;
`endif
                    end
            default: state_n = IDLE;
         endcase
      end
      if (restart) begin
         state_n = VSYNC;
         cnt_n   = '0;
         line_n  = '0;
         busy_n  = 1'b1;
         mode_n  = mode;
         color_n = color;
      end
      // Outputs are registered copies derived from the next segment position.
      x6 = 6'(cnt_n >> 1);
      px = mode_n == 2'd0 ? color_n :
           mode_n == 2'd1 ? (x6[1] ? color_n : 16'h0000) :
           mode_n == 2'd2 ? {5'd0, x6, 5'd0} :
           (line_n >= HALF ? 16'h07E0 : 16'h0000);
      vsync_n = state_n == VSYNC;
      href_n  = state_n == LINE;
      d_n     = href_n ? (cnt_n[0] ? px[7:0] : px[15:8]) : 8'h00;
   end
endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb_dvp_pattern_tx: directed self-checking bench for dvp_pattern_tx with default parameters.
module tb_dvp_pattern_tx;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [15:0] color = 16'h0000;
   logic busy, frame_done, pclk, vsync, href, prev_c;
   logic [7:0] frame_cnt, d;
   int errs = 0, checks = 0;
   byte unsigned q[$];
   int gaps[$], dt[$];
   int vs_clk, done_n, done_t, first_t, dz_bad, act, gapc, drop_t;
   int exp_dt[3];

   dvp_pattern_tx dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .color(color),
      .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
      .pclk(pclk), .vsync(vsync), .href(href), .d(d)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input logic [1:0] m, input logic [15:0] c, input int i);
      int y, x;
      logic [15:0] p;
      y = i / 32;
      x = (i % 32) / 2;
      case (m)
         2'd0:    p = c;
         2'd1:    p = ((x / 2) % 2 == 1) ? c : 16'h0000;
         2'd2:    p = 16'(x * 32);
         default: p = (y >= 4) ? 16'h07E0 : 16'h0000;
      endcase
      return (i % 2 == 0) ? p[15:8] : p[7:0];
   endfunction

   // Runs one frame from its start edge N up to edge N+590 and checks its shape and pixels.
   task automatic run_frame(input logic [1:0] m, input logic [15:0] c, input int extra_t);
      int cur_gap, bad, gbad;
      bit seen;
      logic prev_p;
      mode = m; color = c; start = 1'b1;
      tick;
      start = 1'b0; mode = ~m; color = ~c;
      check("start_busy", busy, 1);
      check("start_vsync", vsync, 1);
      check("start_pclk", pclk, 0);
      q.delete(); gaps.delete();
      vs_clk = vsync ? 1 : 0;
      done_n = 0; done_t = -1; first_t = -1; dz_bad = 0; cur_gap = 0; seen = 0; prev_p = pclk;
      for (int t = 1; t <= 590; t++) begin
         if (t == extra_t) start = 1'b1;
         tick;
         start = 1'b0;
         if (vsync) vs_clk++;
         if (frame_done) begin
            done_n++;
            if (done_t < 0) done_t = t;
         end
         if (!href && d != 8'h00) dz_bad++;
         if (pclk && !prev_p) begin
            if (href) begin
               if (first_t < 0) first_t = t;
               if (seen && cur_gap > 0) gaps.push_back(cur_gap);
               q.push_back(d);
               cur_gap = 0;
               seen = 1;
            end else cur_gap++;
         end
         prev_p = pclk;
      end
      check("end_done", frame_done, 1);
      check("end_busy", busy, 0);
      check("end_pclk", pclk, 0);
      check("done_count", done_n, 1);
      check("done_edge", done_t, 590);
      check("vsync_clks", vs_clk, 6);
      check("first_byte_edge", first_t, 11);
      check("d_zero_outside_href", dz_bad, 0);
      check("href_bytes", q.size(), 256);
      check("line_gaps", gaps.size(), 7);
      gbad = 0;
      foreach (gaps[k]) if (gaps[k] != 4) gbad++;
      check("gap_len", gbad, 0);
      bad = 0;
      foreach (q[i]) if (q[i] !== exp_byte(m, c, i)) bad++;
      check("pixel_bytes", bad, 0);
   endtask

   initial begin
      rst = 1'b1;
      tick; tick;
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_cnt", frame_cnt, 0);
      check("rst_pclk", pclk, 0);
      check("rst_vsync", vsync, 0);
      check("rst_href", href, 0);
      check("rst_d", d, 0);
      rst = 1'b0;
      repeat (5) tick;
      check("idle_pclk", pclk, 0);
      check("idle_busy", busy, 0);

      run_frame(2'd0, 16'hF81F, 0);
      check("a_cnt", frame_cnt, 1);
      check("a_b0", q[0], 8'hF8);
      check("a_b1", q[1], 8'h1F);

      run_frame(2'd2, 16'h0000, 100);
      check("b_cnt", frame_cnt, 2);
      check("b_b1", q[1], 8'h00);
      check("b_b3", q[3], 8'h20);
      check("b_b5", q[5], 8'h40);
      check("b_b7", q[7], 8'h60);
      check("b_b30", q[30], 8'h01);
      check("b_b31", q[31], 8'hE0);

      run_frame(2'd3, 16'hFFFF, 0);
      check("c_cnt", frame_cnt, 3);
      check("c_b127", q[127], 8'h00);
      check("c_b128", q[128], 8'h07);
      check("c_b129", q[129], 8'hE0);

      run_frame(2'd1, 16'hABCD, 0);
      check("d_cnt", frame_cnt, 4);
      check("d_b0", q[0], 8'h00);
      check("d_b4", q[4], 8'hAB);
      check("d_b5", q[5], 8'hCD);

      mode = 2'd0; color = 16'h5555; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (30) tick;
      check("mid_href", href, 1);
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_cnt", frame_cnt, 0);
      check("arst_pclk", pclk, 0);
      check("arst_href", href, 0);
      check("arst_d", d, 0);
      check("arst_vsync", vsync, 0);
      tick;
      rst = 1'b0;
      act = 0;
      repeat (20) begin
         tick;
         if (pclk || busy || vsync || href) act++;
      end
      check("post_rst_quiet", act, 0);

      run_frame(2'd0, 16'h1234, 0);
      check("e_cnt", frame_cnt, 1);

`ifdef DVP_TX_CONT_EN
      drop_t = 1181;
      exp_dt[0] = 590; exp_dt[1] = 1180; exp_dt[2] = 1770;
`else
      drop_t = 1183;
      exp_dt[0] = 590; exp_dt[1] = 1181; exp_dt[2] = 1772;
`endif
      dt.delete();
      gapc = 0;
      mode = 2'd0; color = 16'h00FF; start = 1'b1;
      tick;
      prev_c = pclk;
      for (int t = 1; t <= 1800; t++) begin
         if (t == drop_t) start = 1'b0;
         tick;
`ifdef DVP_TX_CONT_EN
         if (t <= 1770 && pclk == prev_c) gapc++;
`else
         if (t < 1772 && !busy) gapc++;
`endif
         if (frame_done) dt.push_back(t);
         prev_c = pclk;
      end
      check("multi_frames", dt.size(), 3);
      for (int k = 0; k < 3; k++) check("multi_done_edge", dt.size() > k ? dt[k] : -1, exp_dt[k]);
`ifdef DVP_TX_CONT_EN
      check("multi_pclk_gaps", gapc, 0);
`else
      check("multi_idle_clks", gapc, 2);
`endif
      check("multi_busy", busy, 0);
      check("multi_cnt", frame_cnt, 4);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/dvp_pattern_tx.md
# dvp_pattern_tx

Synthetic OV7670-style DVP camera source: generates PCLK, VSYNC, HREF and an 8-bit RGB565 byte stream carrying deterministic test frames. It sits on the camera side of the microgreen classifier's pixel port. It drives the classifier's camera inputs on the bench or FPGA bring-up board, so feature extraction and BNN inference can be exercised without a physical sensor.

## Interface
Parameters:
- H_ACTIVE, 16: active pixels per line (2 bytes each); ≥2, even
- H_BLANK, 4: HREF-low PCLK periods after each line; ≥1
- V_ACTIVE, 8: active lines per frame; ≥2, even
- VSYNC_W, 3: VSYNC-high PCLK periods at frame start; ≥1
- V_BACK, 2: PCLK periods between VSYNC fall and first HREF; ≥1
- V_FRONT, 2: PCLK periods after last line's blanking before frame end; ≥1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame request, sampled in IDLE
- mode  in  2  pattern select, latched at start
- color  in  16  RGB565 fill value, latched at start
- busy  out  1  frame in progress
- frame_done  out  1  one-clk pulse at frame end
- frame_cnt  out  8  completed frames, wraps 255→0
- pclk  out  1  pixel clock, clk/2 while busy, low in IDLE
- vsync  out  1  frame sync, active high
- href  out  1  line valid, active high
- d  out  8  pixel byte

## Operation
- States: IDLE → VSYNC → VBACK → LINE → HBLANK → (LINE, or VFRONT after line V_ACTIVE-1) → IDLE.
- A PCLK period is 2 clk cycles. pclk toggles every clk while busy. vsync, href, d and state/segment counters update only on the edge where pclk goes 1→0 (or on the start edge), so they are stable across every pclk rising edge.
- VSYNC: vsync=1 for VSYNC_W periods. VBACK: all low for V_BACK periods.
- LINE: href=1 for 2*H_ACTIVE periods. Byte order per pixel is high byte then low byte: {R[4:0],G[5:3]}, then {G[2:0],B[4:0]}.
- HBLANK: href=0, d=0 for H_BLANK periods.
- VFRONT: all low for V_FRONT periods.
- d=0 whenever href=0.
- Pixel value p(x,y), x = column 0..H_ACTIVE-1, y = line 0..V_ACTIVE-1:
  - mode 0: color
  - mode 1: x[1] ? color : 16'h0000
  - mode 2: {5'd0, x[5:0], 5'd0} (green ramp; x zero-extended)
  - mode 3: y ≥ V_ACTIVE/2 ? 16'h07E0 : 16'h0000 (green lower half)
- mode and color are latched in IDLE on start and held for the whole frame.
- start while busy is ignored.
- End of VFRONT: frame_done=1 for one clk, frame_cnt+1 (modulo 256), return to IDLE, busy=0, pclk=0.

## Timing
- Reset (async, immediate, also mid-frame): state IDLE, busy=0, frame_done=0, frame_cnt=0, pclk=0, vsync=0, href=0, d=0, latched mode/color=0. On release, nothing is emitted until start.
- start high at edge N in IDLE → after edge N: busy=1, vsync=1, pclk=0. First pclk rise after edge N+1.
- Frame length F = 2*(VSYNC_W + V_BACK + V_ACTIVE*(2*H_ACTIVE + H_BLANK) + V_FRONT) clk. Default F=590.
- frame_done high during cycle after edge N+F; busy low from the same edge. The earliest next start is accepted at edge N+F+1.
- First data byte is present at the pclk rise at edge N+2*(VSYNC_W+V_BACK)+1.
- Counters are sized to max parameter value. Line/column counters reset to 0 at frame start and never wrap mid-frame.

## Configuration
- DVP_TX_CONT_EN defined: continuous mode. If start is high on the final VFRONT falling edge, the block pulses frame_done, increments frame_cnt, and enters VSYNC on that same edge. busy stays 1 and pclk keeps toggling without gap. mode/color are re-latched there. If start is low, it goes to IDLE as normal.
- Undefined: single-shot. Always returns to IDLE after VFRONT; a new frame needs start sampled in IDLE.

## Test plan
- Reset: assert rst mid-LINE with defaults → same cycle all outputs 0, frame_cnt=0; no pclk activity after release until start.
- mode 0, color=16'hF81F, defaults: 8 lines × 32 href-high pclk rises. Bytes alternate F8,1F. frame_done at edge N+590, frame_cnt=1.
- mode 2: line 0 bytes at pclk rises read 00,00,00,20,00,40,00,60,… (x=0..3). href low exactly 4 periods between lines; vsync high exactly 6 clk.
- mode 3: lines 0-3 all 00 bytes; lines 4-7 bytes 07,E0 repeated.
- start pulsed at N+100 while busy → ignored; exactly one frame_done. Second start at N+591 produces frame_cnt=2.
- DVP_TX_CONT_EN, start held high for 3 frames → frame_done at N+590, N+1180, N+1770. pclk never stops between frames. Third frame ends in IDLE after start drops; frame_cnt=3. Without the macro, same stimulus gives back-to-back single frames, each separated by one IDLE cycle.
